int_sched: RTL and testbench
============================

INT_SCHED -- requirements
Module: int_sched

Interface
REQ-001 SHALL have parameter INT_NUM, default 8, number of interrupt sources (1..32).
REQ-002 SHALL have parameter Aw, default 3, Wishbone word-address width.
REQ-003 SHALL have parameter SELw, default 4; TAGw, default 3; Dw, default 32 (Wishbone sel/tag/data widths).
REQ-004 SHALL have parameter RR, default 1; 1 selects round-robin arbitration, 0 selects fixed priority with lowest index highest.
REQ-005 SHALL have one clock and an asynchronous, active-low reset, named as below.
REQ-006 clk  in  1  clock; all state on the rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 sa_dat_i in Dw, sa_sel_i in SELw, sa_addr_i in Aw, sa_tag_i in TAGw, sa_stb_i in 1, sa_cyc_i in 1, sa_we_i in 1: Wishbone slave inputs.
REQ-009 sa_dat_o out Dw, sa_ack_o out 1, sa_err_o out 1 (tied 0), sa_rty_o out 1 (tied 0): Wishbone slave outputs.
REQ-010 int_i  in  INT_NUM  level-sensitive requests from peripheral interrupt outputs, synchronous to clk.
REQ-011 irq_o  out  1  single interrupt line to the processor.

Function
REQ-012 Register map (word address) SHALL be: 0 GER (bit0 global enable, RW); 1 IER (enable mask, RW); 2 PEND (RO); 3 CLAIM (RO with side effect); 4 EOI (WO); 5 INSVC (RO, bit31 = busy, bits[4:0] = in-service id). Unmapped reads SHALL return 0; unmapped writes SHALL be ignored.
REQ-013 sa_ack_o SHALL be registered as sa_stb_i && !sa_ack_o, giving one-cycle latency and one ack per strobe; sa_dat_o SHALL be valid in the ack cycle.
REQ-014 Register side effects SHALL occur only in the cycle where sa_stb_i && !sa_ack_o holds.
REQ-015 PEND bit i SHALL set on the edge after int_i[i] && IER[i], except for the in-service source. It SHALL clear when that source is claimed, or when IER[i] is written 0.
REQ-016 FSM SHALL have states IDLE, REQ and SERVICE.
  - IDLE->REQ when GER && |PEND.
  - REQ->IDLE when GER=0 or PEND becomes 0.
  - REQ->SERVICE on a CLAIM read that returns nonzero.
  - SERVICE->IDLE on an EOI write whose data equals in-service id+1.
REQ-017 irq_o SHALL be 1 exactly when the state register is REQ.
REQ-018 A CLAIM read in REQ SHALL return winner id+1, clear PEND[winner], latch the in-service id and advance the RR pointer to winner+1 modulo INT_NUM.
REQ-019 A CLAIM read in IDLE or SERVICE SHALL return 0 with no state change; nesting is not supported.
REQ-020 The RR winner SHALL be the first set PEND bit searching upward from the pointer, with wrap-around. When RR=0 the pointer SHALL be held at 0.
REQ-021 An EOI with a mismatched id, or an EOI outside SERVICE, SHALL be ignored.
REQ-022 Latency SHALL be: int_i rising at edge N gives PEND at N+1 and irq_o at N+2.
REQ-023 When a PEND set and a claim-clear hit the same bit in the same cycle, the clear SHALL win.
REQ-024 A level source still high after EOI SHALL re-pend on the next edge.

Reset
REQ-025 While reset=0, all of the following SHALL be 0: GER, IER, PEND, in-service id, busy, RR pointer, sa_ack_o, irq_o. The FSM SHALL be in IDLE.
REQ-026 Reset asserted mid-service SHALL abandon the service with no EOI required.

Structure
REQ-027 Register address localparams and FSM state encodings SHALL live in a shared package, int_sched_pkg.
REQ-028 The rotate-search priority selector SHALL be a sub-module, int_rr_arbiter, with ports req, pointer, grant_onehot, grant_id and valid.
REQ-029 The RTL implementation SHALL be between 120 and 400 lines.

Verification
REQ-030 GER=1, IER=0xFF, int_i=0x08 -> irq_o=1 two cycles later; CLAIM returns 4; irq_o=0; EOI 4 -> IDLE.
REQ-031 RR=1, int_i=0x81 held, repeated claim/EOI -> CLAIM sequence 1,8,1,8.
REQ-032 RR=0, int_i=0x81 held -> CLAIM always returns 1.
REQ-033 Claim of id 3 followed by EOI 5 -> INSVC stays 0x80000002; a second CLAIM returns 0.
REQ-034 GER=0 with int_i=0x01 -> PEND=0x01 and irq_o=0; GER=1 -> irq_o=1 within 2 cycles.
REQ-035 reset driven low in SERVICE -> all outputs 0 and INSVC=0 after release.

Source files
------------

// File: rtl/int_sched_pkg.sv
// Shared definitions for the interrupt scheduler: register map, FSM states
// and the round-robin pointer helper.
package int_sched_pkg;

    // Width of a source id (up to 32 sources)
    localparam int unsigned ID_W = 5;

    // Wishbone word-address register map
    localparam logic [31:0] ADDR_GER   = 32'd0;
    localparam logic [31:0] ADDR_IER   = 32'd1;
    localparam logic [31:0] ADDR_PEND  = 32'd2;
    localparam logic [31:0] ADDR_CLAIM = 32'd3;
    localparam logic [31:0] ADDR_EOI   = 32'd4;
    localparam logic [31:0] ADDR_INSVC = 32'd5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    // Pointer position just after a winner, wrapping at n sources
    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id,
                                                 input int unsigned     n);
        if (32'(id) + 32'd1 >= n) return '0;
        return id + ID_W'(1);
    endfunction

endpackage

// File: rtl/int_rr_arbiter.sv
// Rotating-search priority selector: first set request at or above the
// pointer, wrapping around to index 0.
module int_rr_arbiter
    import int_sched_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] pointer,
    output logic [N-1:0]    grant_onehot,
    output logic [ID_W-1:0] grant_id,
    output logic            valid
);

    // Rotate requests so the pointer lands at bit 0, pick the lowest set bit
    always_comb begin
        logic [N-1:0] w_rot;
        int unsigned  w_off;
        int unsigned  w_sum;
        w_rot        = N'({req, req} >> pointer);
        w_off        = 0;
        w_sum        = 0;
        valid        = 1'b0;
        grant_id     = '0;
        grant_onehot = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!valid && w_rot[k]) begin
                valid = 1'b1;
                w_off = k;
            end
        end
        w_sum = 32'(pointer) + w_off;
        if (w_sum >= N) w_sum = w_sum - N;
        grant_id = ID_W'(w_sum);
        for (int unsigned j = 0; j < N; j++) begin
            grant_onehot[j] = valid && (w_sum == j);
        end
    end

endmodule

// File: rtl/int_sched.sv
// Interrupt scheduler with a Wishbone register slave: pends enabled level
// requests, raises a single irq, hands out ids through CLAIM and retires
// them through EOI.
module int_sched
    import int_sched_pkg::*;
#(
    parameter int unsigned INT_NUM = 8,
    parameter int unsigned Aw      = 3,
    parameter int unsigned SELw    = 4,
    parameter int unsigned TAGw    = 3,
    parameter int unsigned Dw      = 32,
    parameter int unsigned RR      = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [Dw-1:0]      sa_dat_i,
    input  logic [SELw-1:0]    sa_sel_i,
    input  logic [Aw-1:0]      sa_addr_i,
    input  logic [TAGw-1:0]    sa_tag_i,
    input  logic               sa_stb_i,
    input  logic               sa_cyc_i,
    input  logic               sa_we_i,
    output logic [Dw-1:0]      sa_dat_o,
    output logic               sa_ack_o,
    output logic               sa_err_o,
    output logic               sa_rty_o,
    input  logic [INT_NUM-1:0] int_i,
    output logic               irq_o
);

    logic               r_ack;
    logic [Dw-1:0]      r_dat;
    logic               r_ger;
    logic [INT_NUM-1:0] r_ier;
    logic [INT_NUM-1:0] r_pend;
    logic [ID_W-1:0]    r_insvc;
    logic [ID_W-1:0]    r_ptr;
    logic               r_busy;
    logic               r_irq;
    state_t             r_state;

    logic               w_acc;
    logic               w_rd;
    logic               w_wr;
    logic [31:0]        w_addr;
    logic [31:0]        w_wdata;
    logic [31:0]        w_rdata;
    logic [INT_NUM-1:0] w_grant_oh;
    logic [ID_W-1:0]    w_grant_id;
    logic               w_valid;
    logic               w_claim;
    logic               w_eoi;
    logic               w_ier_wr;
    logic [INT_NUM-1:0] w_svc_mask;
    logic [INT_NUM-1:0] w_set;
    logic [INT_NUM-1:0] w_clr;
    logic               w_unused;

    assign w_acc    = sa_stb_i && !r_ack;
    assign w_rd     = w_acc && !sa_we_i;
    assign w_wr     = w_acc && sa_we_i;
    assign w_addr   = 32'(sa_addr_i);
    assign w_wdata  = 32'(sa_dat_i);
    assign w_unused = ^{sa_sel_i, sa_tag_i, sa_cyc_i};

    assign w_claim  = w_rd && (w_addr == ADDR_CLAIM) && (r_state == ST_REQ) && w_valid;
    assign w_eoi    = w_wr && (w_addr == ADDR_EOI) && (r_state == ST_SERVICE) &&
                      (w_wdata == 32'(r_insvc) + 32'd1);
    assign w_ier_wr = w_wr && (w_addr == ADDR_IER);

    int_rr_arbiter #(.N(INT_NUM)) u_arb (
        .req          (r_pend),
        .pointer      (r_ptr),
        .grant_onehot (w_grant_oh),
        .grant_id     (w_grant_id),
        .valid        (w_valid)
    );

    // Mask for the source currently in service; it may not re-pend
    always_comb begin
        w_svc_mask = '0;
        for (int unsigned j = 0; j < INT_NUM; j++) begin
            w_svc_mask[j] = r_busy && (32'(r_insvc) == j);
        end
    end

    // Clear (claim or IER disable) overrides a same-cycle set
    assign w_set = int_i & r_ier & ~w_svc_mask;
    assign w_clr = (w_claim ? w_grant_oh : '0) |
                   (w_ier_wr ? ~w_wdata[INT_NUM-1:0] : '0);

    // Read data multiplexer
    always_comb begin
        w_rdata = '0;
        case (w_addr)
            ADDR_GER:   w_rdata = {31'd0, r_ger};
            ADDR_IER:   w_rdata = 32'(r_ier);
            ADDR_PEND:  w_rdata = 32'(r_pend);
            ADDR_CLAIM: w_rdata = w_claim ? 32'(w_grant_id) + 32'd1 : '0;
            ADDR_INSVC: w_rdata = {r_busy, 26'd0, r_insvc};
            default:    w_rdata = '0;
        endcase
    end

    // Bus handshake: one registered ack per strobe, data valid with ack
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= sa_stb_i && !r_ack;
            r_dat <= w_rd ? Dw'(w_rdata) : '0;
        end
    end

    // Control registers and pending bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ger  <= 1'b0;
            r_ier  <= '0;
            r_pend <= '0;
        end else begin
            if (w_wr && (w_addr == ADDR_GER)) r_ger <= w_wdata[0];
            if (w_ier_wr)                     r_ier <= w_wdata[INT_NUM-1:0];
            r_pend <= (r_pend | w_set) & ~w_clr;
        end
    end

    // Scheduler FSM with service bookkeeping and registered irq
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_irq   <= 1'b0;
            r_busy  <= 1'b0;
            r_insvc <= '0;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_ger && |r_pend) begin
                        r_state <= ST_REQ;
                        r_irq   <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (w_claim) begin
                        r_state <= ST_SERVICE;
                        r_irq   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_insvc <= w_grant_id;
                        r_ptr   <= (RR != 0) ? next_ptr(w_grant_id, INT_NUM) : '0;
                    end else if (!r_ger || (r_pend == '0)) begin
                        r_state <= ST_IDLE;
                        r_irq   <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (w_eoi) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_insvc <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_irq   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign sa_ack_o = r_ack;
    assign sa_dat_o = r_dat;
    assign sa_err_o = 1'b0;
    assign sa_rty_o = 1'b0;
    assign irq_o    = r_irq;

endmodule

// File: tb/tb_int_sched.sv
// Scoreboard bench for int_sched: a round-robin instance and a fixed-priority
// instance share all stimulus; expected bus results are queued at issue time
// and compared when the ack appears.
module tb_int_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] dat_i = '0;
    logic [3:0]  sel_i = 4'hF;
    logic [2:0]  addr_i = '0;
    logic [2:0]  tag_i = '0;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic        we = 1'b0;
    logic [7:0]  int_i = '0;

    logic [31:0] dat_rr, dat_fp;
    logic        ack_rr, ack_fp, err_rr, err_fp, rty_rr, rty_fp, irq_rr, irq_fp;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        bit          is_rd;
        logic [31:0] exp_rr;
        logic [31:0] exp_fp;
    } sb_t;
    sb_t sb[$];

    always #5 clk = ~clk;

    int_sched #(.INT_NUM(8), .Aw(3), .SELw(4), .TAGw(3), .Dw(32), .RR(1)) u_dut_rr (
        .clk(clk), .reset(reset), .sa_dat_i(dat_i), .sa_sel_i(sel_i), .sa_addr_i(addr_i),
        .sa_tag_i(tag_i), .sa_stb_i(stb), .sa_cyc_i(cyc), .sa_we_i(we),
        .sa_dat_o(dat_rr), .sa_ack_o(ack_rr), .sa_err_o(err_rr), .sa_rty_o(rty_rr),
        .int_i(int_i), .irq_o(irq_rr)
    );

    int_sched #(.INT_NUM(8), .Aw(3), .SELw(4), .TAGw(3), .Dw(32), .RR(0)) u_dut_fp (
        .clk(clk), .reset(reset), .sa_dat_i(dat_i), .sa_sel_i(sel_i), .sa_addr_i(addr_i),
        .sa_tag_i(tag_i), .sa_stb_i(stb), .sa_cyc_i(cyc), .sa_we_i(we),
        .sa_dat_o(dat_fp), .sa_ack_o(ack_fp), .sa_err_o(err_fp), .sa_rty_o(rty_fp),
        .int_i(int_i), .irq_o(irq_fp)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Response side of the scoreboard
    always @(negedge clk) begin
        sb_t e;
        if (reset && (ack_rr || ack_fp)) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", {30'd0, ack_rr, ack_fp}, 32'd0);
            end else begin
                e = sb.pop_front();
                check({e.tag, "_ack"}, {30'd0, ack_rr, ack_fp}, 32'd3);
                if (e.is_rd) begin
                    check({e.tag, "_rr"}, dat_rr, e.exp_rr);
                    check({e.tag, "_fp"}, dat_fp, e.exp_fp);
                end
            end
        end
    end

    task automatic wait_ack(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (ack_rr) begin
                seen = 1'b1;
                break;
            end
        end
        stb = 1'b0;
        cyc = 1'b0;
        we  = 1'b0;
        if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wb_rd(input string tag, input logic [2:0] addr,
                         input logic [31:0] exp_rr, input logic [31:0] exp_fp);
        sb_t e;
        e.tag = tag; e.is_rd = 1'b1; e.exp_rr = exp_rr; e.exp_fp = exp_fp;
        sb.push_back(e);
        @(posedge clk);
        #1;
        addr_i = addr; we = 1'b0; stb = 1'b1; cyc = 1'b1;
        wait_ack(tag);
    endtask

    task automatic wb_wr(input string tag, input logic [2:0] addr, input logic [31:0] data);
        sb_t e;
        e.tag = tag; e.is_rd = 1'b0; e.exp_rr = '0; e.exp_fp = '0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        addr_i = addr; dat_i = data; we = 1'b1; stb = 1'b1; cyc = 1'b1;
        wait_ack(tag);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        @(negedge clk);
        check(tag, {30'd0, irq_rr, irq_fp}, {30'd0, exp, exp});
    endtask

    // Wait for both instances to raise irq within a bounded number of cycles
    task automatic wait_irq(input string tag, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (irq_rr && irq_fp) break;
        end
        check(tag, {30'd0, irq_rr, irq_fp}, 32'd3);
    endtask

    task automatic chk_reset_outputs(input string tag);
        check({tag, "_ctl"}, {26'd0, irq_rr, ack_rr, err_rr | rty_rr, irq_fp, ack_fp, err_fp | rty_fp}, 32'd0);
        check({tag, "_dat"}, dat_rr | dat_fp, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        @(posedge clk);
        #1 reset = 1'b1;
        wb_rd("rst_ger",   3'd0, 32'd0, 32'd0);
        wb_rd("rst_ier",   3'd1, 32'd0, 32'd0);
        wb_rd("rst_pend",  3'd2, 32'd0, 32'd0);
        wb_rd("rst_insvc", 3'd5, 32'd0, 32'd0);
        wb_rd("unmap_rd",  3'd6, 32'd0, 32'd0);
        wb_wr("unmap_wr",  3'd7, 32'hFFFF_FFFF);
        wb_rd("unmap_ier", 3'd1, 32'd0, 32'd0);
        wb_rd("idle_claim", 3'd3, 32'd0, 32'd0);

        // Single source: latency, claim, exclusion while in service, re-pend
        wb_wr("A_ger", 3'd0, 32'd1);
        wb_wr("A_ier", 3'd1, 32'hFF);
        wb_rd("A_ger_rd", 3'd0, 32'd1, 32'd1);
        @(posedge clk);
        #1 int_i = 8'h08;
        chk_irq("A_irq_n0", 1'b0);
        chk_irq("A_irq_n1", 1'b0);
        chk_irq("A_irq_n2", 1'b1);
        wb_rd("A_claim", 3'd3, 32'd4, 32'd4);
        chk_irq("A_irq_svc", 1'b0);
        wb_rd("A_pend_svc", 3'd2, 32'd0, 32'd0);
        wb_rd("A_insvc", 3'd5, 32'h8000_0003, 32'h8000_0003);
        wb_wr("A_eoi", 3'd4, 32'd4);
        wb_rd("A_repend", 3'd2, 32'h08, 32'h08);
        int_i = 8'h00;
        wb_rd("A_claim2", 3'd3, 32'd4, 32'd4);
        wb_wr("A_eoi2", 3'd4, 32'd4);
        chk_irq("A_irq_done", 1'b0);

        // Mismatched EOI is ignored, nested claim returns 0
        int_i = 8'h04;
        wait_irq("C_irq", 5);
        wb_rd("C_claim", 3'd3, 32'd3, 32'd3);
        int_i = 8'h00;
        wb_wr("C_eoi_bad", 3'd4, 32'd5);
        wb_rd("C_insvc", 3'd5, 32'h8000_0002, 32'h8000_0002);
        wb_rd("C_claim_nest", 3'd3, 32'd0, 32'd0);
        chk_irq("C_irq_svc", 1'b0);
        wb_wr("C_eoi", 3'd4, 32'd3);
        wb_rd("C_pend", 3'd2, 32'd0, 32'd0);
        chk_irq("C_irq_done", 1'b0);

        // Reset in the middle of a service
        int_i = 8'h02;
        wait_irq("R_irq", 5);
        wb_rd("R_claim", 3'd3, 32'd2, 32'd2);
        chk_irq("R_irq_svc", 1'b0);
        #1 reset = 1'b0;
        int_i = 8'h00;
        #1;
        chk_reset_outputs("R_async");
        repeat (2) @(negedge clk);
        chk_reset_outputs("R_held");
        @(posedge clk);
        #1 reset = 1'b1;
        wb_rd("R_ger",   3'd0, 32'd0, 32'd0);
        wb_rd("R_ier",   3'd1, 32'd0, 32'd0);
        wb_rd("R_insvc", 3'd5, 32'd0, 32'd0);
        wb_rd("R_claim_after", 3'd3, 32'd0, 32'd0);
        chk_irq("R_irq", 1'b0);

        // Two held sources: round-robin alternates, fixed priority repeats
        wb_wr("B_ger", 3'd0, 32'd1);
        wb_wr("B_ier", 3'd1, 32'hFF);
        int_i = 8'h81;
        for (int k = 0; k < 4; k++) begin
            logic [31:0] exp_rr;
            exp_rr = (k % 2 == 0) ? 32'd1 : 32'd8;
            wait_irq($sformatf("B_irq%0d", k), 8);
            wb_rd($sformatf("B_claim%0d", k), 3'd3, exp_rr, 32'd1);
            wb_wr($sformatf("B_eoi_rr%0d", k), 3'd4, exp_rr);
            wb_wr($sformatf("B_eoi_fp%0d", k), 3'd4, 32'd1);
        end
        int_i = 8'h00;
        wb_wr("B_ier_off", 3'd1, 32'd0);
        wb_rd("B_pend_clr", 3'd2, 32'd0, 32'd0);
        chk_irq("B_irq_off", 1'b0);

        // Global disable holds irq low while pending is visible
        wb_wr("D_ier", 3'd1, 32'hFF);
        wb_wr("D_ger0", 3'd0, 32'd0);
        int_i = 8'h01;
        repeat (3) @(negedge clk);
        chk_irq("D_irq_masked", 1'b0);
        wb_rd("D_pend", 3'd2, 32'h01, 32'h01);
        chk_irq("D_irq_masked2", 1'b0);
        wb_wr("D_ger1", 3'd0, 32'd1);
        wait_irq("D_irq", 2);
        wb_rd("D_claim", 3'd3, 32'd1, 32'd1);
        int_i = 8'h00;
        wb_wr("D_eoi", 3'd4, 32'd1);
        wb_rd("D_pend_end", 3'd2, 32'd0, 32'd0);
        wb_rd("D_ier_rd", 3'd1, 32'hFF, 32'hFF);
        chk_irq("D_irq_end", 1'b0);

        repeat (2) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
